alarm_screen_renderer: RTL and testbench
========================================

# alarm_screen_renderer

Pixel-data stage that sits directly downstream of the TFT LCD timing controller. It consumes the controller's `counter_h`, `counter_v` and `disp_den` and drives 24-bit RGB for an 800×480 panel. The image is a two-digit seven-segment countdown on a background whose colour follows the alarm mode, with a frame-locked red/black blink while the alarm is active. Mode and digit inputs are sampled once per frame, so the image never tears.

## Interface
- `H_ACT_START`, 211: first active `counter_h` value.
- `V_ACT_START`, 23: first active `counter_v` value.
- `H_ACT`, 800: active width in pixels.
- `V_ACT`, 480: active height in lines.
- `H_LAST`, 1055: last `counter_h` value of a line.
- `V_LAST`, 524: last `counter_v` value of a frame.
- `BLINK_FRAMES`, 30: frames per blink half-period; must be ≥1.
- `clk`  in  1  pixel clock, the same clock as the timing controller.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `counter_h`  in  11  horizontal counter from the timing controller.
- `counter_v`  in  10  vertical counter from the timing controller.
- `disp_den`  in  1  display enable from the timing controller; used only for checking alignment, never for gating.
- `armed`  in  1  system armed.
- `alarm_active`  in  1  alarm firing.
- `digit_tens`  in  4  BCD tens digit.
- `digit_ones`  in  4  BCD ones digit.
- `disp_r`, `disp_g`, `disp_b`  out  8 each  pixel colour.

## Operation
- **Frame boundary.** The frame boundary is the cycle where `counter_h==H_LAST && counter_v==V_LAST`. In that cycle the block latches `armed`, `alarm_active`, `digit_tens` and `digit_ones` into shadow registers. All rendering uses only the shadow values.
- **Blink counter.** On each frame boundary:
  - If the new shadow alarm is 1, `frame_cnt` increments. When it reaches BLINK_FRAMES-1, it wraps to 0 and `blink_phase` toggles.
  - If the new shadow alarm is 0, `frame_cnt` and `blink_phase` are both forced to 0. An alarm therefore always starts on the red phase.
- **Active region.** The region is `H_ACT_START ≤ counter_h < H_ACT_START+H_ACT` and `V_ACT_START ≤ counter_v < V_ACT_START+V_ACT`.
- **Pixel coordinates.** `x = counter_h - H_ACT_START` (10 bits) and `y = counter_v - V_ACT_START` (9 bits). Both are valid only inside the active region.
- **Digit boxes.** Each box is 80×160, spanning y 160..319. The tens box spans x 300..379 and the ones box spans x 420..499.
- **Box-local segment areas (bx, by), inclusive.** Lettering follows the usual seven-segment layout: a top, b top-right, c bottom-right, d bottom, e bottom-left, f top-left, g middle.
  - a: by 0..15.
  - b: bx 64..79, by 0..79.
  - c: bx 64..79, by 80..159.
  - d: by 144..159.
  - e: bx 0..15, by 80..159.
  - f: bx 0..15, by 0..79.
  - g: by 72..87.
- **Segment decode.** BCD values 0..9 use standard seven-segment patterns. Values 10..15 render as a dash (g only).
- **Colours by shadow mode.** A pixel is foreground when it falls on a lit segment; otherwise it is background.
  - alarm=1, blink_phase 0: background FF0000, foreground FFFFFF.
  - alarm=1, blink_phase 1: background 000000, foreground FFFFFF.
  - alarm=0, armed=1: background 000040, foreground 00FF00.
  - alarm=0, armed=0: background 000000, foreground FFFFFF.
- **Blanking.** Any pixel outside the active region outputs 000000.

## Timing
- **Pipeline.** Two register stages from the counters to RGB.
  - Stage 1 registers x, y, the active flag, and the two in-box flags with box-local coordinates.
  - Stage 2 registers the RGB.
- **Alignment.** RGB for counters sampled at cycle t appears at t+2. This is the same latency the timing controller uses for `disp_den`, so RGB is non-zero only in cycles where `disp_den`=1.
- **Reset values.** `rst` clears `disp_r`, `disp_g` and `disp_b` to 0, all shadow registers to 0, `frame_cnt` to 0, `blink_phase` to 0, and every pipeline flag to 0.
- **Reset mid-frame.** After reset deasserts, the block renders in the idle colours (shadow regs are 0) until the first frame boundary.
- **Input changes mid-frame.** No visible effect until the next frame boundary, which takes effect from the first active pixel of the next frame.
- **Simultaneous events.** If an input changes in the exact frame-boundary cycle, the value present in that cycle is the one latched.

## Structure
- **Package `tft_timing_pkg`** holds:
  - timing constants: H_ACT_START, V_ACT_START, H_ACT, V_ACT, H_LAST, V_LAST;
  - digit box origins and sizes, and segment thickness (16);
  - colour constants: C_RED, C_BLACK, C_WHITE, C_GREEN, C_DKBLUE.
- **Sub-module `seg7_decode`**, combinational: 4-bit BCD in, 7-bit segment mask (a..g) out. It is instantiated twice.
- The rest of the block (frame and blink logic, the two-stage pixel pipeline) lives in the top module.

## Test plan
- **Idle frame.** Reset, then drive counters from a timing-controller model with armed=0, alarm=0, digits 1 and 2.
  - Pixel (x=340, y=165), segment a of "1": 000000, because segment a is not lit for 1.
  - Pixel (x=490, y=165), segment b of "2": FFFFFF.
  - Every cycle with `disp_den`=0 shows RGB 000000.
- **Armed, mid-frame change.** Assert armed mid-frame.
  - Remainder of the current frame: background 000000.
  - Next frame: background pixel (0,0) is 000040; segment pixels are 00FF00.
- **Alarm blink.** Set alarm_active=1 with BLINK_FRAMES=2.
  - Background sequence per frame: FF0000, FF0000, 000000, 000000, FF0000.
  - Drop the alarm: the next frame is 000040 or 000000 according to armed. Re-raise it: the first frame is FF0000.
- **Invalid BCD.** Set digit_ones=4'hC. Only the g band (by 72..87) of the ones box is FFFFFF in the idle colours.
- **Alignment.** Over two full frames, assert that (RGB≠0) implies `disp_den`=1. Assert that the first active pixel appears exactly 2 cycles after `counter_h`=211 on line 23.
- **Reset mid-frame.** Assert `rst` for 1 cycle during an alarm frame. The next cycle RGB is 0, and rendering stays in the idle colours until the next frame boundary.

Source files
------------

// File: rtl/tft_timing_pkg.sv
// Shared timing, geometry and colour constants for the 800x480 alarm screen.
// Also holds the segment-area helper used by the pixel pipeline.
package tft_timing_pkg;

  localparam int H_ACT_START = 211;
  localparam int V_ACT_START = 23;
  localparam int H_ACT       = 800;
  localparam int V_ACT       = 480;
  localparam int H_LAST      = 1055;
  localparam int V_LAST      = 524;

  localparam int TENS_X0 = 300;
  localparam int ONES_X0 = 420;
  localparam int BOX_Y0  = 160;
  localparam int BOX_W   = 80;
  localparam int BOX_H   = 160;
  localparam int SEG_T   = 16;

  typedef logic [23:0] rgb_t;
  // Segment masks are ordered {a, b, c, d, e, f, g}, a in the MSB.
  typedef logic [6:0]  seg_mask_t;

  localparam rgb_t C_RED    = 24'hFF0000;
  localparam rgb_t C_BLACK  = 24'h000000;
  localparam rgb_t C_WHITE  = 24'hFFFFFF;
  localparam rgb_t C_GREEN  = 24'h00FF00;
  localparam rgb_t C_DKBLUE = 24'h000040;

  localparam seg_mask_t SEG_DASH = 7'b000_0001;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_ARMED,
    MODE_ALARM_RED,
    MODE_ALARM_DARK
  } mode_e;

  typedef struct packed {
    logic       armed;
    logic       alarm;
    logic [3:0] tens;
    logic [3:0] ones;
  } shadow_t;

  // Which segment areas a box-local pixel falls into; overlaps are intended
  // (corners belong to both the bar and the post they join).
  function automatic seg_mask_t seg_area(logic [6:0] bx, logic [7:0] by);
    logic left, right, upper;
    left  = bx < 7'(SEG_T);
    right = bx >= 7'(BOX_W - SEG_T);
    upper = by < 8'(BOX_H / 2);
    return {by < 8'(SEG_T),
            right && upper,
            right && !upper,
            by >= 8'(BOX_H - SEG_T),
            left && !upper,
            left && upper,
            (by >= 8'(BOX_H / 2 - SEG_T / 2)) && (by < 8'(BOX_H / 2 + SEG_T / 2))};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to seven-segment mask {a..g}; non-decimal codes show a dash.
module seg7_decode
  import tft_timing_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_mask_t  seg
);

  // NOTE: seg gets a value on every path (default arm), so no latch is inferred.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = 7'b111_1110;
      4'd1:    seg = 7'b011_0000;
      4'd2:    seg = 7'b110_1101;
      4'd3:    seg = 7'b111_1001;
      4'd4:    seg = 7'b011_0011;
      4'd5:    seg = 7'b101_1011;
      4'd6:    seg = 7'b101_1111;
      4'd7:    seg = 7'b111_0000;
      4'd8:    seg = 7'b111_1111;
      4'd9:    seg = 7'b111_1011;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/alarm_screen_renderer.sv
// Two-digit seven-segment countdown over a mode-coloured background.
// Inputs are shadowed once per frame; RGB lags the counters by two clocks.
module alarm_screen_renderer
  import tft_timing_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] counter_h,
  input  logic [9:0]  counter_v,
  input  logic        disp_den,
  input  logic        armed,
  input  logic        alarm_active,
  input  logic [3:0]  digit_tens,
  input  logic [3:0]  digit_ones,
  output logic [7:0]  disp_r,
  output logic [7:0]  disp_g,
  output logic [7:0]  disp_b
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  shadow_t          shadow_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             blink_phase;
  logic             frame_end;

  assign frame_end = (counter_h == 11'(H_LAST)) && (counter_v == 10'(V_LAST));

  // A freshly raised alarm restarts at frame 0 of the red phase, so every
  // half-period, including the first, lasts exactly BLINK_FRAMES frames.
  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      shadow_q <= '{armed: armed, alarm: alarm_active,
                    tens: digit_tens, ones: digit_ones};
      if (!alarm_active || !shadow_q.alarm) begin
        frame_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  seg_mask_t seg_tens, seg_ones;

  seg7_decode u_dec_tens (.bcd(shadow_q.tens), .seg(seg_tens));
  seg7_decode u_dec_ones (.bcd(shadow_q.ones), .seg(seg_ones));

  // Stage 0: coordinates and box membership. Offsets wrap when the pixel is
  // left of / above an origin, so a single unsigned compare bounds each range.
  logic [10:0] h_off;
  logic [9:0]  v_off, x, tx, ox;
  logic [8:0]  y, by_full;
  logic        active, y_in_box, in_tens, in_ones;
  logic [6:0]  bx;
  logic [7:0]  by;

  always_comb begin
    h_off    = counter_h - 11'(H_ACT_START);
    v_off    = counter_v - 10'(V_ACT_START);
    active   = (counter_h >= 11'(H_ACT_START)) && (h_off < 11'(H_ACT)) &&
               (counter_v >= 10'(V_ACT_START)) && (v_off < 10'(V_ACT));
    x        = h_off[9:0];
    y        = v_off[8:0];
    tx       = x - 10'(TENS_X0);
    ox       = x - 10'(ONES_X0);
    by_full  = y - 9'(BOX_Y0);
    y_in_box = by_full < 9'(BOX_H);
    in_tens  = active && y_in_box && (tx < 10'(BOX_W));
    in_ones  = active && y_in_box && (ox < 10'(BOX_W));
    bx       = in_tens ? tx[6:0] : ox[6:0];
    by       = by_full[7:0];
  end

  logic       s1_active, s1_in_tens, s1_in_ones;
  logic [6:0] s1_bx;
  logic [7:0] s1_by;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_active  <= 1'b0;
      s1_in_tens <= 1'b0;
      s1_in_ones <= 1'b0;
      s1_bx      <= '0;
      s1_by      <= '0;
    end else begin
      s1_active  <= active;
      s1_in_tens <= in_tens;
      s1_in_ones <= in_ones;
      s1_bx      <= bx;
      s1_by      <= by;
    end
  end

  // Stage 1 -> 2: colour select from the shadowed mode and lit segments.
  mode_e mode;
  rgb_t  bg, fg, pix;
  logic  lit;

  always_comb begin
    mode = MODE_IDLE;
    if (shadow_q.alarm) mode = blink_phase ? MODE_ALARM_DARK : MODE_ALARM_RED;
    else if (shadow_q.armed) mode = MODE_ARMED;

    bg = C_BLACK;
    fg = C_WHITE;
    case (mode)
      MODE_ALARM_RED:  bg = C_RED;
      MODE_ARMED: begin
        bg = C_DKBLUE;
        fg = C_GREEN;
      end
      default: ;
    endcase

    lit = (s1_in_tens || s1_in_ones) &&
          |(seg_area(s1_bx, s1_by) & (s1_in_tens ? seg_tens : seg_ones));
    pix = !s1_active ? C_BLACK : (lit ? fg : bg);
  end

  always_ff @(posedge clk) begin
    if (rst) {disp_r, disp_g, disp_b} <= '0;
    else     {disp_r, disp_g, disp_b} <= pix;
  end

  // disp_den carries the controller's own two-cycle alignment; lit pixels
  // outside it would mean the pipeline depth has drifted.
  rgb_inside_den: assert property (@(posedge clk) disable iff (rst)
    ({disp_r, disp_g, disp_b} != 24'd0) |-> disp_den);

endmodule

// File: tb/tb_alarm_screen_renderer.sv
// Bench for alarm_screen_renderer: constant vector table, hand-built frame
// sequences, and random counters checked against a geometric pixel model.
module tb_alarm_screen_renderer;

  localparam int BLINK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] counter_h = '0;
  logic [9:0]  counter_v = '0;
  logic        disp_den = 1'b0;
  logic        armed = 1'b0, alarm_active = 1'b0;
  logic [3:0]  digit_tens = '0, digit_ones = '0;
  logic [7:0]  disp_r, disp_g, disp_b;
  logic [23:0] rgb;

  assign rgb = {disp_r, disp_g, disp_b};

  alarm_screen_renderer #(.BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst(rst), .counter_h(counter_h), .counter_v(counter_v),
    .disp_den(disp_den), .armed(armed), .alarm_active(alarm_active),
    .digit_tens(digit_tens), .digit_ones(digit_ones),
    .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %06h, want %06h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: shadowed inputs plus count of frames since the alarm rose.
  bit   m_armed, m_alarm;
  int   m_tens, m_ones, m_n;

  function automatic string segs_of(int d);
    case (d)
      0: return "abcdef";
      1: return "bc";
      2: return "abdeg";
      3: return "abcdg";
      4: return "bcfg";
      5: return "acdfg";
      6: return "acdefg";
      7: return "abc";
      8: return "abcdefg";
      9: return "abcdfg";
      default: return "g";
    endcase
  endfunction

  function automatic bit on_segment(int d, int bx, int by);
    string s = segs_of(d);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": if (by < 16) return 1;
        "b": if (bx >= 64 && by < 80) return 1;
        "c": if (bx >= 64 && by >= 80) return 1;
        "d": if (by >= 144) return 1;
        "e": if (bx < 16 && by >= 80) return 1;
        "f": if (bx < 16 && by < 80) return 1;
        "g": if (by >= 72 && by < 88) return 1;
        default: ;
      endcase
    end
    return 0;
  endfunction

  function automatic bit is_active(int h, int v);
    return h >= 211 && h < 1011 && v >= 23 && v < 503;
  endfunction

  function automatic logic [23:0] model_rgb(int h, int v);
    int x = h - 211;
    int y = v - 23;
    logic [23:0] bg, fg;
    bit lit = 0;
    if (!is_active(h, v)) return 24'h000000;
    if (m_alarm) begin
      bg = ((m_n / BLINK) % 2 == 0) ? 24'hFF0000 : 24'h000000;
      fg = 24'hFFFFFF;
    end else if (m_armed) begin
      bg = 24'h000040;
      fg = 24'h00FF00;
    end else begin
      bg = 24'h000000;
      fg = 24'hFFFFFF;
    end
    if (y >= 160 && y < 320) begin
      if (x >= 300 && x < 380)      lit = on_segment(m_tens, x - 300, y - 160);
      else if (x >= 420 && x < 500) lit = on_segment(m_ones, x - 420, y - 160);
    end
    return lit ? fg : bg;
  endfunction

  task automatic model_frame();
    m_n     = alarm_active ? (m_alarm ? m_n + 1 : 0) : 0;
    m_alarm = alarm_active;
    m_armed = armed;
    m_tens  = int'(digit_tens);
    m_ones  = int'(digit_ones);
  endtask

  task automatic model_reset();
    m_armed = 0; m_alarm = 0; m_tens = 0; m_ones = 0; m_n = 0;
  endtask

  logic [23:0] prev_exp = '0;
  bit          prev_act = 0;

  // One pixel clock: present counters, advance, then compare the output that
  // belongs to the previous step's counters (two cycles after presentation).
  task automatic step(input int h, input int v, input bit do_rst);
    logic [23:0] e_cur;
    bit          a_cur;
    counter_h = 11'(h);
    counter_v = 10'(v);
    rst       = do_rst;
    if (do_rst) begin
      e_cur = '0;
      a_cur = 0;
      model_reset();
    end else begin
      e_cur = model_rgb(h, v);
      a_cur = is_active(h, v);
      if (h == 1055 && v == 524) model_frame();
    end
    @(posedge clk);
    #1;
    cyc++;
    rst      = 1'b0;
    disp_den = do_rst ? 1'b0 : prev_act;
    if (do_rst) check("reset_rgb", rgb, 24'h000000);
    else        check("pixel", rgb, prev_exp);
    if (rgb != 24'h0) check("den_align", 24'(disp_den), 24'd1);
    prev_exp = e_cur;
    prev_act = a_cur;
  endtask

  task automatic boundary();
    step(1055, 524, 0);
  endtask

  // Present one pixel, flush one cycle, then check its colour.
  task automatic show(input int x, input int y, input logic [23:0] want, input string name);
    step(x + 211, y + 23, 0);
    step(0, 0, 0);
    check(name, rgb, want);
  endtask

  typedef struct {
    int          x;
    int          y;
    bit          arm;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(int x, int y, bit arm, logic [3:0] t, logic [3:0] o,
                              logic [23:0] e);
    vec_t r;
    r.x = x; r.y = y; r.arm = arm; r.tens = t; r.ones = o; r.exp = e;
    return r;
  endfunction

  initial begin
    logic [23:0] blink_seq[5];
    int c0, first_nz;

    vecs[0]  = mk(340, 165, 0, 4'd1, 4'd2, 24'h000000);
    vecs[1]  = mk(490, 165, 0, 4'd1, 4'd2, 24'hFFFFFF);
    vecs[2]  = mk(370, 200, 0, 4'd1, 4'd2, 24'hFFFFFF);
    vecs[3]  = mk(0,   0,   1, 4'd1, 4'd2, 24'h000040);
    vecs[4]  = mk(490, 165, 1, 4'd1, 4'd2, 24'h00FF00);
    vecs[5]  = mk(799, 479, 1, 4'd1, 4'd2, 24'h000040);
    vecs[6]  = mk(800, 100, 1, 4'd1, 4'd2, 24'h000000);
    vecs[7]  = mk(-1,  100, 1, 4'd1, 4'd2, 24'h000000);
    vecs[8]  = mk(460, 240, 0, 4'd1, 4'hC, 24'hFFFFFF);
    vecs[9]  = mk(460, 180, 0, 4'd1, 4'hC, 24'h000000);
    vecs[10] = mk(420, 230, 0, 4'd1, 4'hC, 24'h000000);
    vecs[11] = mk(460, 247, 0, 4'd1, 4'hC, 24'hFFFFFF);
    vecs[12] = mk(460, 248, 0, 4'd1, 4'hC, 24'h000000);
    vecs[13] = mk(305, 240, 0, 4'd8, 4'd0, 24'hFFFFFF);
    vecs[14] = mk(460, 240, 0, 4'd8, 4'd0, 24'h000000);
    vecs[15] = mk(379, 319, 1, 4'd7, 4'd5, 24'h00FF00);
    vecs[16] = mk(380, 240, 1, 4'd7, 4'd5, 24'h000040);
    vecs[17] = mk(460, 310, 0, 4'd4, 4'd9, 24'hFFFFFF);

    blink_seq = '{24'hFF0000, 24'hFF0000, 24'h000000, 24'h000000, 24'hFF0000};

    // Reset state, then a mid-frame stretch rendered in idle colours.
    step(0, 0, 1);
    step(0, 0, 1);
    digit_tens = 4'd1;
    digit_ones = 4'd2;
    show(0, 0, 24'h000000, "post_reset_idle_bg");

    // Constant vector table; each row gets its own frame.
    for (int i = 0; i < 18; i++) begin
      armed      = vecs[i].arm;
      digit_tens = vecs[i].tens;
      digit_ones = vecs[i].ones;
      boundary();
      show(vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("table%0d", i));
    end

    // Armed asserted mid-frame takes effect only after the next boundary.
    armed = 0; digit_tens = 4'd1; digit_ones = 4'd2;
    boundary();
    show(0, 0, 24'h000000, "idle_bg");
    armed = 1;
    show(0, 0, 24'h000000, "armed_same_frame");
    show(490, 165, 24'hFFFFFF, "armed_same_frame_fg");
    boundary();
    show(0, 0, 24'h000040, "armed_next_bg");
    show(490, 165, 24'h00FF00, "armed_next_fg");

    // Blink with two frames per half-period, then drop and re-raise.
    alarm_active = 1;
    for (int i = 0; i < 5; i++) begin
      boundary();
      show(0, 0, blink_seq[i], $sformatf("blink%0d", i));
    end
    show(490, 165, 24'hFFFFFF, "blink_fg");
    alarm_active = 0;
    boundary();
    show(0, 0, 24'h000040, "alarm_drop");
    alarm_active = 1;
    boundary();
    show(0, 0, 24'hFF0000, "alarm_reraise");

    // Reset during an alarm frame falls back to idle until the next boundary.
    step(300, 200, 1);
    show(0, 0, 24'h000000, "reset_mid_idle");
    boundary();
    show(0, 0, 24'hFF0000, "reset_mid_next_frame");

    // First active pixel of line 23 shows exactly two cycles after h=211.
    alarm_active = 0;
    armed = 1;
    boundary();
    c0 = -1;
    first_nz = -1;
    for (int h = 205; h < 220; h++) begin
      if (h == 211) c0 = cyc;
      step(h, 23, 0);
      if (first_nz < 0 && rgb != 24'h0) first_nz = cyc;
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0);
      if (first_nz < 0 && rgb != 24'h0) first_nz = cyc;
    end
    check("first_px_latency", 24'(first_nz - c0), 24'd2);

    // A full line through both boxes against the model.
    armed = 0;
    digit_tens = 4'd8;
    digit_ones = 4'd8;
    boundary();
    for (int h = 0; h <= 1055; h++) step(h, 23 + 240, 0);

    // Random counters and inputs, including input changes on the boundary.
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 199);
      if ($urandom_range(0, 15) == 0) armed = 1'($urandom);
      if ($urandom_range(0, 9) == 0)  alarm_active = 1'($urandom);
      if ($urandom_range(0, 19) == 0) digit_tens = 4'($urandom);
      if ($urandom_range(0, 19) == 0) digit_ones = 4'($urandom);
      if (r == 0)        step(0, 0, 1);
      else if (r < 20)   boundary();
      else if (r < 110)  step($urandom_range(290, 510) + 211, $urandom_range(150, 330) + 23, 0);
      else               step($urandom_range(0, 1055), $urandom_range(0, 524), 0);
    end
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
